alu_seq_responder: RTL

Handshake-wrapped, multi-cycle 64-bit Y86 ALU. It is the responder end of the operand/result interface the execute stage and ALU benches drive. It accepts an operand pair plus a function code and computes the result LSB-first in SLICE_W-bit slices, one slice per cycle, with a registered carry. It returns the result and the Y86 condition codes (ZF, SF, OF) under a valid/ready handshake.

---
 rtl/y86_alu_pkg.sv | 19 +
 rtl/alu_slice.sv | 39 +++
 rtl/alu_seq_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/y86_alu_pkg.sv
// Shared definitions for the sequential Y86 ALU: function codes and FSM states.
package y86_alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic fun_is_sub(input logic [3:0] fun);
      return fun == ALU_SUB;
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU slice; SUB is b + ~a + cin with cin=1 on the LSB slice.
module alu_slice
   import y86_alu_pkg::*;
#(
   parameter int SLICE_W = 16
) (
   input  logic [3:0]         fun,
   input  logic [SLICE_W-1:0] a_s,
   input  logic [SLICE_W-1:0] b_s,
   input  logic               cin,
   output logic [SLICE_W-1:0] r_s,
   output logic               cout
);

   logic [SLICE_W:0] sum;

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      sum  = '0;
      r_s  = '0;
      cout = 1'b0;
      case (fun)
         ALU_ADD: begin
            sum  = {1'b0, b_s} + {1'b0, a_s} + {{SLICE_W{1'b0}}, cin};
            r_s  = sum[SLICE_W-1:0];
            cout = sum[SLICE_W];
         end
         ALU_SUB: begin
            sum  = {1'b0, b_s} + {1'b0, ~a_s} + {{SLICE_W{1'b0}}, cin};
            r_s  = sum[SLICE_W-1:0];
            cout = sum[SLICE_W];
         end
         ALU_AND: r_s = a_s & b_s;
         ALU_XOR: r_s = a_s ^ b_s;
         default: ;  // illegal codes produce zero
      endcase
   end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshake-wrapped multi-cycle Y86 ALU: computes LSB-first, one SLICE_W slice per cycle.
module alu_seq_responder
   import y86_alu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_fun,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   // SLICE_W must divide WIDTH exactly.
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
   logic [3:0]       fun_r;
   logic [KW-1:0]    k;
   logic             carry;

   logic [SLICE_W-1:0] a_s, b_s, r_s;
   logic               cout;
   logic               accept, last, release_out;
   logic               of_nxt;

   assign accept      = in_valid & in_ready;
   assign release_out = out_valid & out_ready;
   assign last        = (k == K_LAST);

   // ---------------- FSM ----------------
   // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (accept) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- slice datapath ----------------
   assign a_s = a_r[k*SLICE_W +: SLICE_W];
   assign b_s = b_r[k*SLICE_W +: SLICE_W];

   alu_slice #(.SLICE_W(SLICE_W)) u_slice (
      .fun  (fun_r),
      .a_s  (a_s),
      .b_s  (b_s),
      .cin  (carry),
      .r_s  (r_s),
      .cout (cout)
   );

   // Full value as it will look once the current slice lands; flags are taken from it.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[k*SLICE_W +: SLICE_W] = r_s;
   end

   always_comb begin
      of_nxt = 1'b0;
      case (fun_r)
         ALU_ADD: of_nxt = (a_r[WIDTH-1] == b_r[WIDTH-1]) & (acc_nxt[WIDTH-1] != b_r[WIDTH-1]);
         ALU_SUB: of_nxt = (a_r[WIDTH-1] != b_r[WIDTH-1]) & (acc_nxt[WIDTH-1] != b_r[WIDTH-1]);
         default: of_nxt = 1'b0;
      endcase
   end

   // Partial slices accumulate in acc; result only changes when the last slice lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         fun_r  <= ALU_ADD;
         acc    <= '0;
         k      <= '0;
         carry  <= 1'b0;
         result <= '0;
         zf     <= 1'b0;
         sf     <= 1'b0;
         of     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r   <= a;
                  b_r   <= b;
                  fun_r <= alu_fun;
                  acc   <= '0;
                  k     <= '0;
                  carry <= fun_is_sub(alu_fun);
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= cout;
               if (last) begin
                  // Top-slice carry is dropped: arithmetic wraps modulo 2^WIDTH.
                  k      <= '0;
                  carry  <= 1'b0;
                  result <= acc_nxt;
                  zf     <= (acc_nxt == '0);
                  sf     <= acc_nxt[WIDTH-1];
                  of     <= of_nxt;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   logic unused_release;
   assign unused_release = release_out;

endmodule
